// File: rtl/map_port_arbiter.sv
// map_port_arbiter: shares map RAM port b among pacman and two ghosts.
// Optional MAP_ARB_PACMAN_PRIO_EN: pacman always wins, ghosts round-robin.
module map_port_arbiter #(
    parameter int RD_LAT = 2,
    parameter int ROWS   = 30,
    parameter int COLS   = 40
) (
    input  logic         CLOCK_50,
    input  logic         reset_n,
    input  logic [2:0]   req,
    input  logic [14:0]  req_row,
    input  logic [17:0]  req_col,
    input  logic [11:0]  req_code,
    output logic [2:0]   gnt,
    output logic [2:0]   done,
    output logic [3:0]   old_code,
    output logic         err,
    output logic         busy,
    output logic [4:0]   ram_addr,
    output logic         ram_wren,
    output logic [159:0] ram_wrdata,
    input  logic [159:0] ram_rddata
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t         state, state_d;
    logic [1:0]     cnt, cnt_d;
    logic [1:0]     last, last_d;
    logic [1:0]     idx, idx_d;
    logic [5:0]     col, col_d;
    logic [3:0]     code, code_d;
    logic [2:0]     gnt_d, done_d;
    logic           err_d, wren_d;
    logic [4:0]     addr_d;
    logic [159:0]   wrdata_d;
    logic [3:0]     old_d;

    logic [1:0]     sel;
    logic [4:0]     s_row;
    logic [5:0]     s_col;
    logic [3:0]     s_code;
    logic [8:0]     lo;
    logic [3:0]     old_f;
    logic [159:0]   merged;

    // Pick the next requester to serve from the request levels.
`ifdef MAP_ARB_PACMAN_PRIO_EN
    always_comb begin
        if (req[0])
            sel = 2'd0;
        else if (req[1] && req[2])
            sel = (last == 2'd1) ? 2'd2 : 2'd1;
        else if (req[1])
            sel = 2'd1;
        else
            sel = 2'd2;
    end
`else
    logic       found;
    logic [1:0] nxt;
    always_comb begin
        sel   = last;
        found = 1'b0;
        nxt   = 2'd0;
        for (int k = 1; k <= 3; k++) begin
            nxt = 2'((int'(last) + k) % 3);
            if (!found && req[nxt]) begin
                sel   = nxt;
                found = 1'b1;
            end
        end
    end
`endif

    // Route the selected requester's operands.
    always_comb begin
        unique case (sel)
            2'd0: begin
                s_row  = req_row[4:0];
                s_col  = req_col[5:0];
                s_code = req_code[3:0];
            end
            2'd1: begin
                s_row  = req_row[9:5];
                s_col  = req_col[11:6];
                s_code = req_code[7:4];
            end
            default: begin
                s_row  = req_row[14:10];
                s_col  = req_col[17:12];
                s_code = req_code[11:8];
            end
        endcase
    end

    // Locate the latched cell in the row; column 0 is the top nibble.
    always_comb begin
        lo     = 9'd156 - {1'b0, col, 2'b00};
        old_f  = ram_rddata[lo +: 4];
        merged = (ram_rddata & ~(160'hF << lo)) | ({156'd0, code} << lo);
    end

    // Next-state and next-output logic for the read-modify-write sequence.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        last_d   = last;
        idx_d    = idx;
        col_d    = col;
        code_d   = code;
        gnt_d    = 3'b000;
        done_d   = 3'b000;
        err_d    = 1'b0;
        wren_d   = 1'b0;
        addr_d   = ram_addr;
        wrdata_d = ram_wrdata;
        old_d    = old_code;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    idx_d      = sel;
`ifdef MAP_ARB_PACMAN_PRIO_EN
                    if (sel != 2'd0)
                        last_d = sel;
`else
                    last_d     = sel;
`endif
                    col_d      = s_col;
                    code_d     = s_code;
                    gnt_d[sel] = 1'b1;
                    if (s_row >= 5'(ROWS) || s_col >= 6'(COLS)) begin
                        state_d     = DONE;
                        err_d       = 1'b1;
                        done_d[sel] = 1'b1;
                        old_d       = 4'd0;
                    end else begin
                        state_d = READ;
                        addr_d  = s_row;
                        cnt_d   = 2'd0;
                    end
                end
            end
            READ: begin
                if (cnt == 2'(RD_LAT - 1)) begin
                    state_d  = WRITE;
                    old_d    = old_f;
                    wrdata_d = merged;
                    wren_d   = 1'b1;
                end else begin
                    cnt_d = cnt + 2'd1;
                end
            end
            WRITE: begin
                state_d     = DONE;
                done_d[idx] = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            last       <= 2'd2;
            idx        <= 2'd0;
            col        <= 6'd0;
            code       <= 4'd0;
            gnt        <= 3'b000;
            done       <= 3'b000;
            err        <= 1'b0;
            busy       <= 1'b0;
            ram_addr   <= 5'd0;
            ram_wren   <= 1'b0;
            ram_wrdata <= 160'd0;
            old_code   <= 4'd0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            last       <= last_d;
            idx        <= idx_d;
            col        <= col_d;
            code       <= code_d;
            gnt        <= gnt_d;
            done       <= done_d;
            err        <= err_d;
            busy       <= (state_d != IDLE);
            ram_addr   <= addr_d;
            ram_wren   <= wren_d;
            ram_wrdata <= wrdata_d;
            old_code   <= old_d;
        end
    end

endmodule
